// File: rtl/merger_out_pkg.sv
// Shared types and helpers for the merger output serializer.
// The state encoding and the beat-count helper are used by the top.
package merger_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_IN_RECS    = 16;
    localparam int DEF_OUT_RECS   = 4;
    localparam int DEF_CNT_WIDTH  = 32;

    // Output beats needed to drain one input tuple.
    function automatic int beats_of(input int in_recs, input int out_recs);
        return in_recs / out_recs;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tuple_buffer_2.sv
// Two-entry FIFO holding whole tuples from the merger tree root.
// Supports same-cycle enqueue and dequeue; flush empties it.
module tuple_buffer_2 #(
    parameter int WIDTH = 2048
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (enq) begin
                wr_ptr <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign occupancy = count;

endmodule

// File: rtl/merger_out_serializer.sv
// Buffers 16-record tuples from the merger root and re-emits them as
// narrow beats, masking the tail of the run and pulsing completion.
module merger_out_serializer
    import merger_out_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IN_RECS    = DEF_IN_RECS,
    parameter int OUT_RECS   = DEF_OUT_RECS,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_start,
    input  logic [CNT_WIDTH-1:0]           i_run_len,
    input  logic [IN_RECS*DATA_WIDTH-1:0]  i_data,
    input  logic                           i_write,
    output logic                           o_ready,
    output logic [OUT_RECS*DATA_WIDTH-1:0] o_data,
    output logic [OUT_RECS-1:0]            o_keep,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [CNT_WIDTH-1:0]           o_rec_count,
    output logic                           o_overflow
);

    localparam int NBEATS = beats_of(IN_RECS, OUT_RECS);
    localparam int BW     = idx_width(NBEATS);
    localparam int BEAT_W = OUT_RECS * DATA_WIDTH;

    if (IN_RECS % OUT_RECS != 0) begin : g_bad_ratio
        $error("OUT_RECS must divide IN_RECS");
    end

    state_t                      state;
    state_t                      state_nxt;
    logic [CNT_WIDTH-1:0]        run_len;
    logic [CNT_WIDTH-1:0]        rec_count;
    logic [BW-1:0]               beat;
    logic                        overflow;
    logic [1:0]                  occ;
    logic [IN_RECS*DATA_WIDTH-1:0] head;
    logic [BEAT_W-1:0]           beat_data [NBEATS];
    logic                        enq;
    logic                        deq;
    logic                        flush;
    logic                        fire;
    logic                        last_beat;
    logic                        done_hit;
    logic [CNT_WIDTH-1:0]        remaining;
    logic [CNT_WIDTH-1:0]        pop;
    logic [OUT_RECS-1:0]         keep;

    tuple_buffer_2 #(
        .WIDTH(IN_RECS * DATA_WIDTH)
    ) u_buf (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .enq      (enq),
        .enq_data (i_data),
        .deq      (deq),
        .flush    (flush),
        .head     (head),
        .occupancy(occ)
    );

    for (genvar g = 0; g < NBEATS; g++) begin : g_slice
        assign beat_data[g] = head[g*BEAT_W +: BEAT_W];
    end

    // Handshake signals derive only from registered state.
    assign o_ready   = (state == ST_RUN) && (occ != 2'd2);
    assign o_valid   = (state == ST_RUN) && (occ != 2'd0);
    assign fire      = o_valid && i_ready;
    assign enq       = i_write && o_ready;
    assign last_beat = (beat == BW'(NBEATS - 1));
    assign deq       = fire && last_beat;
    assign flush     = (state == ST_DONE);

    assign remaining = run_len - rec_count;

    always_comb begin
        keep = '0;
        pop  = CNT_WIDTH'(OUT_RECS);
        for (int i = 0; i < OUT_RECS; i++) begin
            keep[i] = (CNT_WIDTH'(i) < remaining);
        end
        if (remaining < CNT_WIDTH'(OUT_RECS)) begin
            pop = remaining;
        end
    end

    assign done_hit = fire && ((rec_count + pop) == run_len);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = (i_run_len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (done_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            run_len   <= '0;
            rec_count <= '0;
            beat      <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (i_write && !o_ready) begin
                overflow <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        run_len   <= i_run_len;
                        rec_count <= '0;
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        rec_count <= rec_count + pop;
                        beat      <= last_beat ? '0 : beat + BW'(1);
                    end
                end
                default: begin
                    beat <= '0;
                end
            endcase
        end
    end

    assign o_data      = o_valid ? beat_data[beat] : '0;
    assign o_keep      = o_valid ? keep : '0;
    assign o_busy      = (state == ST_RUN);
    assign o_done      = (state == ST_DONE);
    assign o_rec_count = rec_count;
    assign o_overflow  = overflow;

endmodule
